// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, drives byte-addressable memory,
// splits misaligned half/word accesses into byte operations and extends loads.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [2:0]  mem_ctl,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, asm_q;
    logic [1:0]  idx_q;

    logic        req_legal, aligned, last_op, active;
    logic [1:0]  last_idx;
    logic [4:0]  lane_sh;
    logic [31:0] ext;

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
            default:                                req_legal = 1'b0;
        endcase
    end

    // Only legal sizes ever reach ISSUE/CAPTURE, so 2'b11 needs no special case.
    always_comb begin
        aligned  = 1'b1;
        last_idx = 2'd0;
        case (f3_q[1:0])
            2'b01: begin aligned = ~addr_q[0];          last_idx = 2'd1; end
            2'b10: begin aligned = (addr_q[1:0] == 2'b00); last_idx = 2'd3; end
            default: begin aligned = 1'b1;              last_idx = 2'd0; end
        endcase
    end

    assign last_op = aligned || (idx_q == last_idx);
    assign active  = (state_q == ISSUE) || (state_q == CAPTURE);
    assign lane_sh = {idx_q, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_legal ? ISSUE : RESP;
            ISSUE:   if (!we_q)       state_d = CAPTURE;
                     else if (last_op) state_d = RESP;
            CAPTURE: state_d = last_op ? RESP : ISSUE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            asm_q   <= 32'h0;
            idx_q   <= 2'd0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    err_q   <= ~req_legal;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    asm_q   <= 32'h0;
                    idx_q   <= 2'd0;
                end
                ISSUE: if (we_q && !last_op) idx_q <= idx_q + 2'd1;
                CAPTURE: begin
                    if (aligned) begin
                        case (f3_q[1:0])
                            2'b00:   asm_q <= {24'h0, mem_rd[7:0]};
                            2'b01:   asm_q <= {16'h0, mem_rd[15:0]};
                            default: asm_q <= mem_rd;
                        endcase
                    end else begin
                        asm_q[lane_sh +: 8] <= mem_rd[7:0];
                    end
                    if (!last_op) idx_q <= idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00:   ext = f3_q[2] ? {24'h0, asm_q[7:0]}  : {{24{asm_q[7]}}, asm_q[7:0]};
            2'b01:   ext = f3_q[2] ? {16'h0, asm_q[15:0]} : {{16{asm_q[15]}}, asm_q[15:0]};
            default: ext = asm_q;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? ext : 32'h0;

    // Split operations walk one byte lane at a time; aligned ones pass through whole.
    assign mem_a   = (active && !aligned) ? addr_q + {30'h0, idx_q} : addr_q;
    assign mem_ctl = (active && aligned) ? {1'b0, f3_q[1:0]} : 3'b000;
    assign mem_wd  = aligned ? wdata_q : {24'h0, wdata_q[lane_sh +: 8]};
    assign mem_we  = (state_q == ISSUE) && we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte memory device, directed scenarios, then randomized
// requests checked against a byte-array reference model of loads and stores.
module tb_lsu_ctrl;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;
    logic [2:0]  mem_ctl;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_ctl(mem_ctl),
        .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory device: 256 bytes aliased by address low byte, registered read.
    logic [7:0]  dev_mem [256];
    logic [31:0] wlog_a   [64];
    logic [31:0] wlog_wd  [64];
    logic [2:0]  wlog_ctl [64];
    int          wlog_cyc [64];
    int          wr_total = 0;
    int          cyc = 0;
    wire  [7:0]  ma = mem_a[7:0];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            dev_mem[ma] <= mem_wd[7:0];
            if (mem_ctl == 3'b001 || mem_ctl == 3'b010) dev_mem[ma + 8'd1] <= mem_wd[15:8];
            if (mem_ctl == 3'b010) begin
                dev_mem[ma + 8'd2] <= mem_wd[23:16];
                dev_mem[ma + 8'd3] <= mem_wd[31:24];
            end
            wlog_a[wr_total % 64]   <= mem_a;
            wlog_wd[wr_total % 64]  <= mem_wd;
            wlog_ctl[wr_total % 64] <= mem_ctl;
            wlog_cyc[wr_total % 64] <= cyc;
            wr_total <= wr_total + 1;
        end
        mem_rd <= {dev_mem[ma + 8'd3], dev_mem[ma + 8'd2], dev_mem[ma + 8'd1], dev_mem[ma]};
    end

    logic [7:0] ref_mem [256];
    int passed = 0, total = 0, fails = 0;
    logic [31:0] last_rdata, last_a;
    logic        last_err;
    logic [2:0]  last_ctl;
    int          last_w0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        bit legal, al;
        int n, lat, expw, cnt, g;
        logic [31:0] v;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        al    = (addr % n) == 0;
        lat   = !legal ? 1 : we ? (al ? 2 : n + 1) : (al ? 3 : 2 * n + 1);
        expw  = (legal && we) ? (al ? 1 : n) : 0;
        v = 32'h0;
        if (legal && !we) begin
            for (int k = 0; k < n; k++) v |= 32'(ref_mem[addr[7:0] + 8'(k)]) << (8 * k);
            if (!f3[2] && n < 4 && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
        end
        if (legal && we)
            for (int k = 0; k < n; k++) ref_mem[addr[7:0] + 8'(k)] = 8'(wdata >> (8 * k));

        g = 0;
        while (!req_ready && g < 50) begin @(posedge clk); #1; g++; end
        check({tag, " ready_wait"}, 32'(g >= 50), 32'd0);
        last_w0 = wr_total;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        last_ctl = mem_ctl; last_a = mem_a;
        cnt = 1;
        while (!resp_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
        last_rdata = resp_rdata; last_err = resp_err;
        check({tag, " latency"}, 32'(cnt), 32'(lat));
        check({tag, " err"}, 32'(last_err), 32'(!legal));
        check({tag, " rdata"}, last_rdata, v);
        @(posedge clk); #1;
        check({tag, " one_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, " ready_back"}, 32'(req_ready), 32'd1);
        check({tag, " writes"}, 32'(wr_total - last_w0), 32'(expw));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_rdata"}, resp_rdata, 32'h0);
        check({tag, " resp_err"}, 32'(resp_err), 32'd0);
        check({tag, " mem_we"}, 32'(mem_we), 32'd0);
        check({tag, " mem_a"}, mem_a, 32'h0);
        check({tag, " mem_wd"}, mem_wd, 32'h0);
        check({tag, " mem_ctl"}, 32'(mem_ctl), 32'd0);
    endtask

    initial begin
        int w0, rv;
        logic [7:0] old43, old44;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int w = 0; w < 64; w++) run_op(1'b1, 3'b010, 32'(w * 4), $urandom, "fill");

        run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10");
        run_op(1'b0, 3'b010, 32'h10, 32'h0, "lw10");
        check("lw10 ctl", 32'(last_ctl), 32'd2);
        check("lw10 val", last_rdata, 32'hDEADBEEF);

        run_op(1'b1, 3'b000, 32'h13, 32'h80, "sb13");
        run_op(1'b0, 3'b000, 32'h13, 32'h0, "lb13");
        check("lb13 val", last_rdata, 32'hFFFFFF80);
        check("lb13 ctl", 32'(last_ctl), 32'd0);
        run_op(1'b0, 3'b100, 32'h13, 32'h0, "lbu13");
        check("lbu13 val", last_rdata, 32'h00000080);
        check("lbu13 ctl", 32'(last_ctl), 32'd0);

        run_op(1'b1, 3'b010, 32'h21, 32'h11223344, "sw21");
        for (int k = 0; k < 4; k++) begin
            rv = (last_w0 + k) % 64;
            check($sformatf("sw21 a%0d", k), wlog_a[rv], 32'h21 + 32'(k));
            check($sformatf("sw21 ctl%0d", k), 32'(wlog_ctl[rv]), 32'd0);
            check($sformatf("sw21 wd%0d", k), wlog_wd[rv], 32'h11223344 >> (8 * k) & 32'hFF);
            check($sformatf("sw21 cyc%0d", k), 32'(wlog_cyc[rv] - wlog_cyc[last_w0 % 64]), 32'(k));
        end
        run_op(1'b0, 3'b010, 32'h21, 32'h0, "lw21");
        check("lw21 val", last_rdata, 32'h11223344);

        run_op(1'b1, 3'b000, 32'h07, 32'h34, "sb07");
        run_op(1'b1, 3'b000, 32'h08, 32'h92, "sb08");
        run_op(1'b0, 3'b001, 32'h07, 32'h0, "lh07");
        check("lh07 val", last_rdata, 32'hFFFF9234);
        run_op(1'b0, 3'b101, 32'h07, 32'h0, "lhu07");
        check("lhu07 val", last_rdata, 32'h00009234);
        run_op(1'b1, 3'b001, 32'hFFFFFFFF, 32'hABCD, "shwrap");
        check("shwrap a0", wlog_a[last_w0 % 64], 32'hFFFFFFFF);
        check("shwrap a1", wlog_a[(last_w0 + 1) % 64], 32'h0);
        check("shwrap wd0", wlog_wd[last_w0 % 64], 32'hCD);
        check("shwrap wd1", wlog_wd[(last_w0 + 1) % 64], 32'hAB);

        run_op(1'b0, 3'b011, 32'h10, 32'h0, "ill011");
        check("ill011 err", 32'(last_err), 32'd1);
        run_op(1'b1, 3'b111, 32'h10, 32'h12345678, "ill111");
        check("ill111 err", 32'(last_err), 32'd1);
        check("ill111 rdata", last_rdata, 32'h0);

        // Reset in the middle of a split store: first two bytes land, nothing else.
        old43 = ref_mem[8'h43]; old44 = ref_mem[8'h44];
        w0 = wr_total;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h41; req_wdata = 32'h55667788;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort pre_writes", 32'(wr_total - w0), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        rv = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (resp_valid) rv++;
        end
        check("abort no_resp", 32'(rv), 32'd0);
        check("abort writes", 32'(wr_total - w0), 32'd2);
        rst_n = 1'b1;
        ref_mem[8'h41] = 8'h88; ref_mem[8'h42] = 8'h77;
        @(posedge clk); #1;
        run_op(1'b0, 3'b100, 32'h41, 32'h0, "rb41");
        check("rb41 val", last_rdata, 32'h88);
        run_op(1'b0, 3'b100, 32'h42, 32'h0, "rb42");
        check("rb42 val", last_rdata, 32'h77);
        run_op(1'b0, 3'b100, 32'h43, 32'h0, "rb43");
        check("rb43 val", last_rdata, 32'(old43));
        run_op(1'b0, 3'b100, 32'h44, 32'h0, "rb44");
        check("rb44 val", last_rdata, 32'(old44));

        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a |= 32'hFFFFFF00;
            run_op(1'($urandom), 3'($urandom), a, $urandom, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
